// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, reset PC, PC step,
// fetch operating modes and small PC helpers used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // Fetch modes, derived from the inflight (I) and skid (S) valid bits.
  //   BOOT    : I=0, S=0  nothing to hand to decode this cycle
  //   STREAM  : I=1, S=0  head comes straight from the memory output
  //   STALLED : S=1       head comes from the skid register
  typedef enum logic [1:0] {
    MODE_BOOT    = 2'b00,
    MODE_STREAM  = 2'b01,
    MODE_STALLED = 2'b10
  } fetch_mode_e;

  // Classify the current fetch mode from the two valid bits.
  function automatic fetch_mode_e fetch_mode(input logic inflight_valid,
                                             input logic skid_valid);
    fetch_mode_e m;
    if (skid_valid) begin
      m = MODE_STALLED;
    end else if (inflight_valid) begin
      m = MODE_STREAM;
    end else begin
      m = MODE_BOOT;
    end
    return m;
  endfunction

  // Force a byte address onto a word boundary (instructions are 4-byte aligned).
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched (pc, instruction) pair.
// A flush (redirect) wins over a load, a load wins over a drain.
module fetch_skid #(
  parameter int PCW = 32,
  parameter int IW  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           load,
  input  logic           drain,
  input  logic [PCW-1:0] load_pc,
  input  logic [IW-1:0]  load_instr,
  output logic           valid,
  output logic [PCW-1:0] pc,
  output logic [IW-1:0]  instr
);

  // Valid bit: dropped by flush or drain, set by a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

  // Payload: only written on a capture that is not being flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= {PCW{1'b0}};
      instr <= {IW{1'b0}};
    end else if (load && !flush) begin
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      pc    <= pc;
      instr <= instr;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage in front of a synchronous-read instruction memory.
// pc_q is the address presented to memory this cycle; the inflight entry is
// the address presented last cycle, whose data is on imem_data now. When
// decode stalls, the inflight pair is parked in a one-entry skid register and
// pc_q stops advancing, so the word after the parked one is simply re-read
// every cycle until the stall clears.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              ADDR     = 10,
  parameter int              DATA     = ILEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [ADDR-1:0] imem_addr,
  input  logic [DATA-1:0] imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [DATA-1:0] out_instr
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            inflight_valid;
  logic [XLEN-1:0] inflight_pc;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [DATA-1:0] skid_instr;

  fetch_mode_e     mode;
  logic            skid_next;
  logic            skid_load;
  logic            skid_drain;

  // Mode decode: decide whether the head will be parked next cycle and
  // whether the skid is captured or drained at this edge.
  always_comb begin
    mode       = fetch_mode(inflight_valid, skid_valid);
    skid_next  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    case (mode)
      MODE_BOOT: begin
        skid_next  = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
      end
      MODE_STREAM: begin
        if (!out_ready) begin
          skid_next = 1'b1;
          skid_load = 1'b1;
        end else begin
          skid_next = 1'b0;
          skid_load = 1'b0;
        end
      end
      MODE_STALLED: begin
        // Inflight data is a re-read of the word after the parked one; ignore it.
        if (out_ready) begin
          skid_next  = 1'b0;
          skid_drain = 1'b1;
        end else begin
          skid_next  = 1'b1;
          skid_drain = 1'b0;
        end
      end
      default: begin
        skid_next  = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
      end
    endcase
  end

  // Next PC: redirect wins; otherwise hold while the head is parked, else step.
  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = align_pc(redirect_pc);
    end else if (skid_next) begin
      pc_next = pc_q;
    end else begin
      pc_next = pc_q + PC_STEP;
    end
  end

  // Presented-address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Inflight tracker: remembers which address the memory is answering now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_valid <= 1'b0;
      inflight_pc    <= {XLEN{1'b0}};
    end else if (redirect_valid) begin
      inflight_valid <= 1'b0;
      inflight_pc    <= inflight_pc;
    end else begin
      inflight_valid <= 1'b1;
      inflight_pc    <= pc_q;
    end
  end

  fetch_skid #(
    .PCW (XLEN),
    .IW  (DATA)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_pc    (inflight_pc),
    .load_instr (imem_data),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  assign imem_addr = pc_q[ADDR+1:2];
  assign out_valid = skid_valid | inflight_valid;
  assign out_pc    = skid_valid ? skid_pc : inflight_pc;
  assign out_instr = skid_valid ? skid_instr : imem_data;

endmodule
